// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting N requesters write access to one shared
// W-bit register, with burst hold (lock), synchronous clear and async reset.
module shared_reg_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic [N-1:0]           req,
    input  logic [N-1:0]           lock,
    input  logic [N*W-1:0]         wdata,
    output logic [W-1:0]           q,
    output logic [N-1:0]           gnt,
    output logic [N-1:0]           ack,
    output logic [$clog2(N)-1:0]   owner,
    output logic                   busy
);

    localparam int unsigned OW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    q_q, q_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    ack_q, ack_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;

    logic [OW-1:0]   rr_winner;
    logic [W-1:0]    owner_wdata;

    // Round-robin search: first requester upward from ptr+1, wrapping at N.
    always_comb begin
        logic          found;
        int unsigned   idx;
        logic [OW-1:0] cand;
        rr_winner = ptr_q;
        found     = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx  = (32'(ptr_q) + k) % N;
            cand = OW'(idx);
            if (!found && req[cand]) begin
                rr_winner = cand;
                found     = 1'b1;
            end
        end
    end

    // Select the write data slice belonging to the current owner.
    always_comb begin
        owner_wdata = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (owner_q == OW'(i)) begin
                owner_wdata = wdata[i*W +: W];
            end
        end
    end

    // Next-state and output logic; clr overrides every transition.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (clr) begin
            state_d = IDLE;
            q_d     = '0;
            gnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_d            = '0;
                        gnt_d[rr_winner] = 1'b1;
                        owner_d          = rr_winner;
                        state_d          = GRANT;
                    end
                end
                GRANT: begin
                    q_d            = owner_wdata;
                    ack_d[owner_q] = 1'b1;
                    state_d        = ACK;
                end
                ACK: begin
                    if (lock[owner_q]) begin
                        state_d = GRANT;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        ptr_d   = owner_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            endcase
        end
    end

    // State registers; ptr resets to N-1 so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            owner_q <= '0;
            ptr_q   <= OW'(N - 1);
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign q     = q_q;
    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign owner = owner_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001: Parameter N, default 4, SHALL set the number of requesters (2..8).
REQ-002: Parameter W, default 8, SHALL set the shared register data width.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005: clr  input  1  SHALL be a synchronous clear request for the shared register.
REQ-006: req  input  N  SHALL carry per-requester write requests; bit i belongs to requester i.
REQ-007: lock  input  N  SHALL carry per-requester burst-hold requests.
REQ-008: wdata  input  N*W  SHALL carry per-requester write data; slice [i*W +: W] belongs to requester i.
REQ-009: q  output  W  SHALL present the shared register contents.
REQ-010: gnt  output  N  SHALL be a one-hot or zero grant vector.
REQ-011: ack  output  N  SHALL be a one-hot or zero write-complete pulse vector.
REQ-012: owner  output  clog2(N)  SHALL give the index of the current or last granted requester.
REQ-013: busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-014: The FSM SHALL have exactly three states: IDLE, GRANT, ACK.
REQ-015: IDLE, req != 0, clr low -> select winner, register gnt and owner, go to GRANT.
REQ-016: Winner selection SHALL be round-robin: first set req bit searching upward from ptr+1 modulo N.
REQ-017: GRANT -> go to ACK; at that edge, q <= wdata slice of owner and ack[owner] <= 1.
REQ-018: ACK SHALL last one cycle; ack SHALL be high only in ACK, so ack is a single-cycle pulse.
REQ-019: Latency SHALL be: req sampled in IDLE at cycle T -> gnt high in T+1 -> q updated and ack high in T+2.
REQ-020: ACK with lock[owner] high -> go to GRANT with the same owner, keeping gnt asserted and ptr unchanged.
REQ-021: ACK with lock[owner] low -> go to IDLE, clear gnt, and set ptr <= owner.
REQ-022: Requester handshake: a requester SHALL deassert req no later than the cycle after its ack, unless it has a further write.
REQ-023: The FSM SHALL ignore req during GRANT and ACK; changes to req in those states SHALL have no effect.
REQ-024: gnt SHALL be high throughout GRANT and ACK and zero in IDLE.
REQ-025: clr sampled high in any state SHALL force all of the following at the next edge:
- q <= 0
- gnt <= 0
- ack <= 0
- state <= IDLE
- ptr unchanged
REQ-026: A transaction aborted by clr SHALL produce no ack; the requester keeps req high and re-arbitrates.
REQ-027: clr SHALL have priority over every other transition, including a GRANT->ACK write in the same cycle.
REQ-028: req == 0 in IDLE -> remain in IDLE; q holds its value.
REQ-029: owner SHALL retain the last granted index while in IDLE.

Reset
REQ-030: While reset is high, the block SHALL immediately and asynchronously hold:
- q = 0, gnt = 0, ack = 0, busy = 0
- owner = 0
- state = IDLE
- ptr = N-1, so requester 0 has first priority
REQ-031: Reset asserted mid-transaction SHALL abort it with no ack; operation resumes from IDLE on the first edge after reset deasserts.

Verification
REQ-032: Scenario: after reset, req=0001, wdata0=8'hA5 -> gnt=0001 at T+1; q=8'hA5 and ack=0001 at T+2; busy=0 at T+3.
REQ-033: Scenario: req=1111 held continuously with distinct data -> grants in order 0,1,2,3,0; each ack one cycle; one write per 3 cycles.
REQ-034: Scenario: req=0100 with lock[2]=1 for 3 writes (data 11,22,33) -> gnt stays 0100; q=11,22,33 on successive ACKs every 2 cycles; ptr=2 after lock drops.
REQ-035: Scenario: clr pulsed during GRANT of requester 1 with q=8'h3C -> q=0 next cycle, no ack, IDLE; requester 1 re-granted on the following arbitration.
REQ-036: Scenario: reset asserted mid-cycle during ACK -> q=0, gnt=0, ack=0 without waiting for a clock edge; req=1000 after release -> requester 3 granted.
